// File: rtl/rv_exec_pkg.sv
// Shared execute-stage constants: one-hot op/opcode/exception indices,
// multiply/divide op selects and the iterative unit state encoding.
package rv_exec_pkg;

  localparam int ALU_ADD    = 0;
  localparam int ALU_SUB    = 1;
  localparam int ALU_SLT    = 2;
  localparam int ALU_SLTU   = 3;
  localparam int ALU_XOR    = 4;
  localparam int ALU_OR     = 5;
  localparam int ALU_AND    = 6;
  localparam int ALU_SLL    = 7;
  localparam int ALU_SRL    = 8;
  localparam int ALU_SRA    = 9;
  localparam int ALU_EQ     = 10;
  localparam int ALU_NEQ    = 11;
  localparam int ALU_GE     = 12;
  localparam int ALU_GEU    = 13;
  localparam int ALU_MUL    = 14;
  localparam int ALU_MULH   = 15;
  localparam int ALU_MULHSU = 16;
  localparam int ALU_MULHU  = 17;
  localparam int ALU_DIV    = 18;
  localparam int ALU_DIVU   = 19;
  localparam int ALU_REM    = 20;
  localparam int ALU_REMU   = 21;
  localparam int ALU_W      = 22;

  localparam int OP_RTYPE   = 0;
  localparam int OP_ITYPE   = 1;
  localparam int OP_LOAD    = 2;
  localparam int OP_STORE   = 3;
  localparam int OP_BRANCH  = 4;
  localparam int OP_JAL     = 5;
  localparam int OP_JALR    = 6;
  localparam int OP_LUI     = 7;
  localparam int OP_AUIPC   = 8;
  localparam int OP_SYSTEM  = 9;
  localparam int OP_FENCE   = 10;
  localparam int OPCODE_W   = 11;

  localparam int EXC_ILLEGAL = 0;
  localparam int EXC_ECALL   = 1;
  localparam int EXC_EBREAK  = 2;
  localparam int EXC_MRET    = 3;
  localparam int EXC_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_e;

  typedef enum logic [2:0] {
    MD_MUL,
    MD_MULH,
    MD_MULHSU,
    MD_MULHU,
    MD_DIV,
    MD_DIVU,
    MD_REM,
    MD_REMU
  } md_op_e;

  function automatic md_op_e md_sel(input logic [ALU_W-1:0] alu);
    md_sel = MD_MUL;
    if (alu[ALU_MULH])   md_sel = MD_MULH;
    if (alu[ALU_MULHSU]) md_sel = MD_MULHSU;
    if (alu[ALU_MULHU])  md_sel = MD_MULHU;
    if (alu[ALU_DIV])    md_sel = MD_DIV;
    if (alu[ALU_DIVU])   md_sel = MD_DIVU;
    if (alu[ALU_REM])    md_sel = MD_REM;
    if (alu[ALU_REMU])   md_sel = MD_REMU;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide on operand magnitudes.
// Divider step is built only with EXECUTE_MD_DIV_EN defined.
module muldiv_iter
  import rv_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            hold_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q;
  logic              neg_q, neg_d;
  logic              sa, sb;
  logic [XLEN-1:0]   opb_q, mag_a, mag_b;
  logic [2*XLEN:0]   p_q, p_step;
  logic [XLEN:0]     up;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sa    = 1'b0;
    sb    = 1'b0;
    neg_d = 1'b0;
    unique case (op_i)
      MD_MULH: begin
        sa    = a_i[XLEN-1];
        sb    = b_i[XLEN-1];
        neg_d = sa ^ sb;
      end
      MD_MULHSU: begin
        sa    = a_i[XLEN-1];
        neg_d = sa;
      end
      // A zero divisor yields all ones, so the sign is never applied.
      MD_DIV: begin
        sa    = a_i[XLEN-1];
        sb    = b_i[XLEN-1];
        neg_d = (sa ^ sb) && (b_i != '0);
      end
      MD_REM: begin
        sa    = a_i[XLEN-1];
        sb    = b_i[XLEN-1];
        neg_d = sa;
      end
      default: ;
    endcase
  end

  assign mag_a = sa ? -a_i : a_i;
  assign mag_b = sb ? -b_i : b_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = BUSY;
        cnt_d   = CW'(XLEN-1);
      end
      BUSY: if (cnt_q == '0) state_d = DONE;
            else cnt_d = cnt_q - 1'b1;
      DONE: if (!hold_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    up     = '0;
    p_step = p_q;
`ifdef EXECUTE_MD_DIV_EN
    if (op_q[2]) begin
      p_step = {p_q[2*XLEN-1:0], 1'b0};
      if (p_step[2*XLEN:XLEN] >= {1'b0, opb_q}) begin
        p_step[2*XLEN:XLEN] = p_step[2*XLEN:XLEN] - {1'b0, opb_q};
        p_step[0]           = 1'b1;
      end
    end else
`endif
    begin
      up     = p_q[2*XLEN:XLEN] + (p_q[0] ? {1'b0, opb_q} : '0);
      p_step = {1'b0, up, p_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      opb_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_i && state_q == IDLE) begin
        op_q  <= op_i;
        neg_q <= neg_d;
        opb_q <= mag_b;
        p_q   <= {{(XLEN+1){1'b0}}, mag_a};
      end else if (state_q == BUSY) begin
        p_q <= p_step;
      end
    end
  end

  assign prod = neg_q ? -p_q[2*XLEN-1:0] : p_q[2*XLEN-1:0];

`ifdef EXECUTE_MD_DIV_EN
  logic [XLEN-1:0] quo, rem;
  assign quo = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
  assign rem = neg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
`endif

  always_comb begin
    result_o = prod[XLEN-1:0];
    unique case (op_q)
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[2*XLEN-1:XLEN];
`ifdef EXECUTE_MD_DIV_EN
      MD_DIV, MD_DIVU: result_o = quo;
      MD_REM, MD_REMU: result_o = rem;
`endif
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: rtl/execute_md.sv
// Execute stage: single-cycle RV32I ALU/branch plus iterative RV-M unit.
// EXECUTE_MD_DIV_EN enables DIV/DIVU/REM/REMU; otherwise they trap ILLEGAL.
module execute_md
  import rv_exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IMM_OUT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALU_W-1:0]     decode_alu_type,
  input  logic [OPCODE_W-1:0]  decode_opcode_type,
  input  logic [EXC_W-1:0]     decode_exception,
  input  logic [4:0]           decode_r_rs1,
  input  logic [4:0]           decode_r_rd,
  input  logic [2:0]           decode_funct3,
  input  logic [XLEN-1:0]      decode_imm,
  input  logic [XLEN-1:0]      decode_pc,
  input  logic [XLEN-1:0]      forward_rs1_data,
  input  logic [XLEN-1:0]      forward_rs2_data,
  output logic [4:0]           execute_rs1,
  output logic [4:0]           execute_rd,
  output logic [XLEN-1:0]      execute_rs1_data,
  output logic [XLEN-1:0]      execute_rs2_data,
  output logic [XLEN-1:0]      execute_result,
  output logic [XLEN-1:0]      execute_rd_wr_data,
  output logic [XLEN-1:0]      execute_pc,
  output logic [IMM_OUT_W-1:0] execute_imm,
  output logic [2:0]           execute_funct3,
  output logic [OPCODE_W-1:0]  execute_opcode_type,
  output logic [EXC_W-1:0]     execute_exception,
  output logic                 execute_rd_wr_en,
  output logic                 execute_rd_valid,
  output logic                 stall_from_execute,
  output logic [XLEN-1:0]      execute_next_pc,
  output logic                 execute_change_pc,
  input  logic                 clk_en,
  input  logic                 stall,
  input  logic                 force_stall,
  input  logic                 flush,
  output logic                 next_clk_en,
  output logic                 next_stall,
  output logic                 next_flush,
  output logic                 md_busy
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]  a, b, alu_out, rd_d, md_res;
  logic [EXC_W-1:0] ill_vec;
  logic is_mul, is_div, is_m, div_ill, start, md_done, md_req_stall, upd;
  logic branch, jal, jalr, redirect, sys, wren_d, rdv_d;

  assign branch = decode_opcode_type[OP_BRANCH];
  assign jal    = decode_opcode_type[OP_JAL];
  assign jalr   = decode_opcode_type[OP_JALR];
  assign sys    = decode_opcode_type[OP_SYSTEM];

  assign a = (jal || decode_opcode_type[OP_AUIPC]) ? decode_pc : forward_rs1_data;
  assign b = (decode_opcode_type[OP_RTYPE] || branch) ? forward_rs2_data : decode_imm;

  always_comb begin
    alu_out = '0;
    unique case (1'b1)
      decode_alu_type[ALU_ADD]:  alu_out = a + b;
      decode_alu_type[ALU_SUB]:  alu_out = a - b;
      decode_alu_type[ALU_SLT]:  alu_out = XLEN'($signed(a) < $signed(b));
      decode_alu_type[ALU_SLTU]: alu_out = XLEN'(a < b);
      decode_alu_type[ALU_XOR]:  alu_out = a ^ b;
      decode_alu_type[ALU_OR]:   alu_out = a | b;
      decode_alu_type[ALU_AND]:  alu_out = a & b;
      decode_alu_type[ALU_SLL]:  alu_out = a << b[SHW-1:0];
      decode_alu_type[ALU_SRL]:  alu_out = a >> b[SHW-1:0];
      decode_alu_type[ALU_SRA]:  alu_out = $signed(a) >>> b[SHW-1:0];
      decode_alu_type[ALU_EQ]:   alu_out = XLEN'(a == b);
      decode_alu_type[ALU_NEQ]:  alu_out = XLEN'(a != b);
      decode_alu_type[ALU_GE]:   alu_out = XLEN'($signed(a) >= $signed(b));
      decode_alu_type[ALU_GEU]:  alu_out = XLEN'(a >= b);
      default:                   alu_out = '0;
    endcase
  end

  always_comb begin
    rd_d = alu_out;
    if (jal || jalr)                        rd_d = decode_pc + XLEN'(4);
    else if (decode_opcode_type[OP_LUI])    rd_d = decode_imm;
    else if (decode_opcode_type[OP_AUIPC])  rd_d = decode_pc + decode_imm;
  end

  assign is_mul = |decode_alu_type[ALU_MULHU:ALU_MUL];
  assign is_div = |decode_alu_type[ALU_REMU:ALU_DIV];
`ifdef EXECUTE_MD_DIV_EN
  assign is_m    = is_mul || is_div;
  assign div_ill = 1'b0;
`else
  assign is_m    = is_mul;
  assign div_ill = is_div;
`endif

  always_comb begin
    ill_vec              = '0;
    ill_vec[EXC_ILLEGAL] = div_ill;
  end

  assign wren_d = !(branch || decode_opcode_type[OP_STORE] ||
                    decode_opcode_type[OP_FENCE] ||
                    (sys && decode_funct3 == 3'b000)) && !div_ill;
  assign rdv_d  = !(decode_opcode_type[OP_LOAD] ||
                    (sys && decode_funct3 != 3'b000));

  assign start        = is_m && clk_en && !stall && !flush && !md_busy;
  assign md_req_stall = start || (md_busy && !md_done);
  assign next_stall   = !flush && (stall || force_stall || md_req_stall);
  assign upd          = !next_stall && !stall && clk_en;

  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .abort_i  (flush),
    .hold_i   (!upd),
    .op_i     (md_sel(decode_alu_type)),
    .a_i      (forward_rs1_data),
    .b_i      (forward_rs2_data),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  assign redirect = (branch && alu_out[0]) || jal || jalr;
  assign execute_next_pc = jalr ?
    ((forward_rs1_data + decode_imm) & {{(XLEN-1){1'b1}}, 1'b0}) :
    (decode_pc + decode_imm);
  assign execute_change_pc = redirect && upd && !flush;
  assign next_flush        = flush || execute_change_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      execute_rs1         <= '0;
      execute_rd          <= '0;
      execute_rs1_data    <= '0;
      execute_rs2_data    <= '0;
      execute_result      <= '0;
      execute_rd_wr_data  <= '0;
      execute_pc          <= '0;
      execute_imm         <= '0;
      execute_funct3      <= '0;
      execute_opcode_type <= '0;
      execute_exception   <= '0;
      execute_rd_wr_en    <= 1'b0;
      execute_rd_valid    <= 1'b0;
      stall_from_execute  <= 1'b0;
      next_clk_en         <= 1'b0;
    end else begin
      if (flush)    execute_rd_wr_en <= 1'b0;
      else if (upd) execute_rd_wr_en <= wren_d;
      if (upd) begin
        execute_rs1         <= decode_r_rs1;
        execute_rd          <= decode_r_rd;
        execute_rs1_data    <= forward_rs1_data;
        execute_rs2_data    <= forward_rs2_data;
        execute_pc          <= decode_pc;
        execute_imm         <= decode_imm[IMM_OUT_W-1:0];
        execute_funct3      <= decode_funct3;
        execute_opcode_type <= decode_opcode_type;
        execute_exception   <= decode_exception | ill_vec;
        execute_rd_valid    <= rdv_d;
        stall_from_execute  <= decode_opcode_type[OP_LOAD] ||
                               decode_opcode_type[OP_STORE];
        execute_result      <= md_done ? md_res : (div_ill ? '0 : alu_out);
        execute_rd_wr_data  <= md_done ? md_res : (div_ill ? '0 : rd_d);
      end
      // Bubble downstream while stalled from here; hold on an upstream stall.
      if (flush)            next_clk_en <= 1'b0;
      else if (!next_stall) next_clk_en <= clk_en;
      else if (!stall)      next_clk_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_md.sv
// Self-checking bench for execute_md: directed pipeline cases plus
// randomized ALU and RV-M ops against an arithmetic reference model.
module tb_execute_md;
  import rv_exec_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [ALU_W-1:0]    alu = '0;
  logic [OPCODE_W-1:0] opc = '0;
  logic [EXC_W-1:0]    exc_in = '0;
  logic [4:0]          rs1a = '0, rda = '0;
  logic [2:0]          f3 = '0;
  logic [31:0]         imm = '0, pc = '0, r1 = '0, r2 = '0;
  logic                clk_en = 1'b1, stall = 1'b0;
  logic                force_stall = 1'b0, flush = 1'b0;

  logic [4:0]          e_rs1, e_rd;
  logic [31:0]         e_rs1d, e_rs2d, e_res, e_wr, e_pc, e_npc;
  logic [11:0]         e_imm;
  logic [2:0]          e_f3;
  logic [OPCODE_W-1:0] e_opc;
  logic [EXC_W-1:0]    e_exc;
  logic                e_wren, e_rdv, e_sfe, e_chg;
  logic                n_ce, n_stall, n_flush, busy;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  execute_md #(.XLEN(32), .IMM_OUT_W(12)) dut (
    .clk(clk), .rst(rst),
    .decode_alu_type(alu), .decode_opcode_type(opc),
    .decode_exception(exc_in), .decode_r_rs1(rs1a), .decode_r_rd(rda),
    .decode_funct3(f3), .decode_imm(imm), .decode_pc(pc),
    .forward_rs1_data(r1), .forward_rs2_data(r2),
    .execute_rs1(e_rs1), .execute_rd(e_rd),
    .execute_rs1_data(e_rs1d), .execute_rs2_data(e_rs2d),
    .execute_result(e_res), .execute_rd_wr_data(e_wr), .execute_pc(e_pc),
    .execute_imm(e_imm), .execute_funct3(e_f3),
    .execute_opcode_type(e_opc), .execute_exception(e_exc),
    .execute_rd_wr_en(e_wren), .execute_rd_valid(e_rdv),
    .stall_from_execute(e_sfe),
    .execute_next_pc(e_npc), .execute_change_pc(e_chg),
    .clk_en(clk_en), .stall(stall), .force_stall(force_stall), .flush(flush),
    .next_clk_en(n_ce), .next_stall(n_stall), .next_flush(n_flush),
    .md_busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int op, input int oc, input logic [31:0] a,
                         input logic [31:0] bv, input logic [31:0] im,
                         input logic [31:0] p);
    alu = '0;
    alu[op] = 1'b1;
    opc = '0;
    opc[oc] = 1'b1;
    r1 = a;
    r2 = bv;
    imm = im;
    pc = p;
  endtask

  function automatic logic [31:0] alu_model(input int op,
      input logic [31:0] a, input logic [31:0] bv);
    case (op)
      ALU_ADD:  return a + bv;
      ALU_SUB:  return a - bv;
      ALU_SLT:  return ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < bv) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ bv;
      ALU_OR:   return a | bv;
      ALU_AND:  return a & bv;
      ALU_SLL:  return a << bv[4:0];
      ALU_SRL:  return a >> bv[4:0];
      default:  return 32'($signed(a) >>> bv[4:0]);
    endcase
  endfunction

  function automatic logic [31:0] m_model(input int op,
      input logic [31:0] a, input logic [31:0] bv);
    logic [63:0] p;
    case (op)
      ALU_MUL: begin
        p = {32'b0, a} * {32'b0, bv};
        return p[31:0];
      end
      ALU_MULH: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{bv[31]}}, bv});
        return p[63:32];
      end
      ALU_MULHSU: begin
        p = $signed({{32{a[31]}}, a}) * $signed({32'b0, bv});
        return p[63:32];
      end
      ALU_MULHU: begin
        p = {32'b0, a} * {32'b0, bv};
        return p[63:32];
      end
      ALU_DIV: begin
        if (bv == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(bv);
      end
      ALU_REM: begin
        if (bv == 0) return a;
        if (a == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(bv);
      end
      ALU_DIVU: return (bv == 0) ? 32'hFFFF_FFFF : a / bv;
      default:  return (bv == 0) ? a : a % bv;
    endcase
  endfunction

  task automatic run_m(input string tag, input int op,
                       input logic [31:0] a, input logic [31:0] bv);
    int n;
    logic [31:0] e;
    e = m_model(op, a, bv);
    present(op, OP_RTYPE, a, bv, 32'd0, 32'h200);
    n = 0;
    while (n < 100) begin
      #1;
      if (!n_stall) break;
      n++;
      @(posedge clk);
      #1;
    end
    tick();
    chk({tag, " stall_cycles"}, n, 33);
    chk({tag, " result"}, e_res, e);
    chk({tag, " wr_data"}, e_wr, e);
    chk({tag, " busy_after"}, busy, 0);
    alu = '0;
  endtask

  initial begin
    int ops[$];
    int op;
    logic [31:0] a, bv, prev;

    tick();
    tick();
    chk("rst result", e_res, 0);
    chk("rst wr_data", e_wr, 0);
    chk("rst wr_en", e_wren, 0);
    chk("rst next_clk_en", n_ce, 0);
    chk("rst md_busy", busy, 0);
    chk("rst pc", e_pc, 0);
    rst = 1'b0;

    rs1a = 5'd3;
    rda  = 5'd9;
    present(ALU_ADD, OP_RTYPE, 32'd5, 32'd7, 32'h123, 32'h40);
    tick();
    chk("add result", e_res, 12);
    chk("add wr_data", e_wr, 12);
    chk("add wr_en", e_wren, 1);
    chk("add rd_valid", e_rdv, 1);
    chk("add next_clk_en", n_ce, 1);
    chk("add rs1", e_rs1, 3);
    chk("add rd", e_rd, 9);
    chk("add rs1_data", e_rs1d, 5);
    chk("add rs2_data", e_rs2d, 7);
    chk("add imm", e_imm, 12'h123);
    chk("add funct3", e_f3, 0);
    chk("add opcode", e_opc, 11'(1) << OP_RTYPE);
    chk("add pc", e_pc, 32'h40);
    chk("add exc", e_exc, 0);
    chk("add stall_from_ex", e_sfe, 0);

    present(ALU_EQ, OP_BRANCH, 32'd3, 32'd3, 32'd16, 32'h100);
    #1;
    chk("beq change_pc", e_chg, 1);
    chk("beq next_pc", e_npc, 32'h110);
    chk("beq next_flush", n_flush, 1);
    tick();
    chk("beq wr_en", e_wren, 0);

    run_m("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd2);
    run_m("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'd2);

`ifdef EXECUTE_MD_DIV_EN
    run_m("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_m("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_m("divu by0", ALU_DIVU, 32'd7, 32'd0);
    run_m("remu by0", ALU_REMU, 32'd7, 32'd0);
`else
    present(ALU_REM, OP_RTYPE, 32'd9, 32'd4, 32'd0, 32'h300);
    #1;
    chk("rem ill no_stall", n_stall, 0);
    tick();
    chk("rem ill exc", e_exc[EXC_ILLEGAL], 1);
    chk("rem ill wr_en", e_wren, 0);
    chk("rem ill result", e_res, 0);
    chk("rem ill busy", busy, 0);
`endif

    ops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
`ifdef EXECUTE_MD_DIV_EN
    ops.push_back(ALU_DIV);
    ops.push_back(ALU_DIVU);
    ops.push_back(ALU_REM);
    ops.push_back(ALU_REMU);
`endif
    for (int i = 0; i < 8; i++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: bv = 32'd0;
        1: bv = 32'hFFFF_FFFF;
        default: bv = $urandom;
      endcase
      run_m("rand_m", op, a, bv);
    end

    prev = '0;
    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(ALU_ADD, ALU_SRA);
      a  = $urandom;
      bv = $urandom;
      prev = alu_model(op, a, bv);
      present(op, OP_RTYPE, a, bv, 32'd0, 32'h400);
      tick();
      chk("rand_alu", e_res, prev);
    end

    present(ALU_MUL, OP_RTYPE, 32'd3, 32'd4, 32'd0, 32'h500);
    repeat (33) tick();
    stall = 1'b1;
    #1;
    chk("done_hold next_stall", n_stall, 1);
    repeat (3) tick();
    chk("done_hold busy", busy, 1);
    chk("done_hold result", e_res, prev);
    stall = 1'b0;
    #1;
    chk("done_rel next_stall", n_stall, 0);
    tick();
    chk("done_rel result", e_res, 12);
    chk("done_rel busy", busy, 0);

`ifdef EXECUTE_MD_DIV_EN
    present(ALU_DIV, OP_RTYPE, 32'd100, 32'd7, 32'd0, 32'h600);
`else
    present(ALU_MUL, OP_RTYPE, 32'd100, 32'd7, 32'd0, 32'h600);
`endif
    tick();
    repeat (9) tick();
    chk("flush pre busy", busy, 1);
    flush = 1'b1;
    #1;
    chk("flush next_stall", n_stall, 0);
    tick();
    flush = 1'b0;
    chk("flush busy", busy, 0);
    chk("flush next_clk_en", n_ce, 0);
    chk("flush wr_en", e_wren, 0);
    present(ALU_ADD, OP_RTYPE, 32'd1, 32'd2, 32'd0, 32'h700);
    #1;
    chk("post_flush stall", n_stall, 0);
    tick();
    chk("post_flush result", e_res, 3);
    chk("post_flush wr_en", e_wren, 1);
    chk("post_flush next_clk_en", n_ce, 1);

    present(ALU_MUL, OP_RTYPE, 32'd6, 32'd7, 32'd0, 32'h800);
    repeat (5) tick();
    chk("mid_mul busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst result", e_res, 0);
    chk("mid_rst wr_data", e_wr, 0);
    chk("mid_rst wr_en", e_wren, 0);
    chk("mid_rst next_clk_en", n_ce, 0);
    chk("mid_rst busy", busy, 0);
    alu = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst busy", busy, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
